// File: rtl/alu_sequencer.sv
// Sequences one instruction through an external ALU: regfile read, execute, writeback; accept-to-done 3 cycles, 4 per instruction.
// instr_ready is low while busy or while ext_we wins in IDLE; optional zero/neg flags via `define ALU_SEQ_FLAGS_EN.
module alu_sequencer #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [15:0]       instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic              ext_we,
    input  logic [3:0]        ext_addr,
    input  logic [DATA_W-1:0] ext_data,
    input  logic [3:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [2:0]        alu_sel,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_out,
`ifdef ALU_SEQ_FLAGS_EN
    output logic              zero_flag,
    output logic              neg_flag,
`endif
    output logic              done,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] regs [NREGS];
    logic [2:0]        op_q;
    logic [3:0]        rd_q;
    logic [3:0]        ra_q;
    logic [3:0]        rb_q;
    logic [DATA_W-1:0] result;

    // Bit 12 of the instruction is reserved and deliberately dropped.
    logic unused_reserved;
    assign unused_reserved = instr[12];

    assign instr_ready = (state == IDLE) && !ext_we;
    assign busy        = (state != IDLE);
    assign dbg_data    = regs[dbg_addr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            op_q    <= '0;
            rd_q    <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            result  <= '0;
            alu_sel <= '0;
            alu_a   <= '0;
            alu_b   <= '0;
            done    <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
`ifdef ALU_SEQ_FLAGS_EN
            zero_flag <= 1'b0;
            neg_flag  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // External writes win over a pending instruction.
                    if (ext_we) begin
                        regs[ext_addr] <= ext_data;
                    end else if (instr_valid) begin
                        op_q  <= instr[15:13];
                        rd_q  <= instr[11:8];
                        ra_q  <= instr[7:4];
                        rb_q  <= instr[3:0];
                        state <= READ;
                    end
                end
                READ: begin
                    alu_sel <= op_q;
                    alu_a   <= regs[ra_q];
                    alu_b   <= regs[rb_q];
                    state   <= EXEC;
                end
                EXEC: begin
                    result <= alu_out;
                    done   <= 1'b1;
                    state  <= WB;
                end
                WB: begin
                    regs[rd_q] <= result;
`ifdef ALU_SEQ_FLAGS_EN
                    zero_flag <= (result == '0);
                    neg_flag  <= result[DATA_W-1];
`endif
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU on alu_sel/alu_a/alu_b.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        ext_we;
    logic [3:0]  ext_addr;
    logic [15:0] ext_data;
    logic [3:0]  dbg_addr;
    logic [15:0] dbg_data;
    logic [2:0]  alu_sel;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_out;
    logic        done;
    logic        busy;
`ifdef ALU_SEQ_FLAGS_EN
    logic        zero_flag;
    logic        neg_flag;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_sequencer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .ext_we      (ext_we),
        .ext_addr    (ext_addr),
        .ext_data    (ext_data),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data),
        .alu_sel     (alu_sel),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_out     (alu_out),
`ifdef ALU_SEQ_FLAGS_EN
        .zero_flag   (zero_flag),
        .neg_flag    (neg_flag),
`endif
        .done        (done),
        .busy        (busy)
    );

    always_comb begin
        alu_out = 16'h0000;
        case (alu_sel)
            3'd0: alu_out = 16'h0000;
            3'd1: alu_out = alu_a + alu_b;
            3'd2: alu_out = alu_a - alu_b;
            3'd3: alu_out = alu_a;
            3'd4: alu_out = alu_a ^ alu_b;
            3'd5: alu_out = alu_a | alu_b;
            3'd6: alu_out = alu_a & alu_b;
            3'd7: alu_out = alu_a + 16'd1;
            default: alu_out = 16'h0000;
        endcase
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic check_reg(input string nm, input logic [3:0] addr, input logic [15:0] exp);
        dbg_addr = addr;
        #1;
        check(nm, {16'h0, dbg_data}, {16'h0, exp});
    endtask

    task automatic ext_write(input logic [3:0] addr, input logic [15:0] data);
        ext_we   = 1'b1;
        ext_addr = addr;
        ext_data = data;
        @(posedge clk);
        #1;
        ext_we = 1'b0;
    endtask

    // Issues one instruction and checks every stage at its expected cycle.
    task automatic issue(input string nm, input logic [2:0] op, input logic [3:0] rd,
                         input logic [3:0] ra, input logic [3:0] rb,
                         input logic [15:0] av, input logic [15:0] bv, input logic [15:0] exp);
        instr       = {op, 1'b1, rd, ra, rb};
        instr_valid = 1'b1;
        #1;
        check({nm, ".ready"}, {31'h0, instr_ready}, 32'd1);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        check({nm, ".busy_read"}, {31'h0, busy}, 32'd1);
        check({nm, ".done_read"}, {31'h0, done}, 32'd0);
        @(posedge clk);
        #1;
        check({nm, ".alu_sel"}, {29'h0, alu_sel}, {29'h0, op});
        check({nm, ".alu_a"}, {16'h0, alu_a}, {16'h0, av});
        check({nm, ".alu_b"}, {16'h0, alu_b}, {16'h0, bv});
        @(posedge clk);
        #1;
        check({nm, ".done_wb"}, {31'h0, done}, 32'd1);
        @(posedge clk);
        #1;
        check({nm, ".done_idle"}, {31'h0, done}, 32'd0);
        check({nm, ".busy_idle"}, {31'h0, busy}, 32'd0);
        check_reg({nm, ".rd"}, rd, exp);
`ifdef ALU_SEQ_FLAGS_EN
        check({nm, ".zero_flag"}, {31'h0, zero_flag}, {31'h0, (exp == 16'h0)});
        check({nm, ".neg_flag"}, {31'h0, neg_flag}, {31'h0, exp[15]});
`endif
    endtask

    typedef struct {
        string       nm;
        logic [2:0]  op;
        logic [3:0]  rd;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [15:0] av;
        logic [15:0] bv;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [9];

    initial begin
        vecs[0] = '{"add",      3'd1, 4'd3,  4'd1,  4'd2,  16'h0005, 16'h0003, 16'h0008};
        vecs[1] = '{"sub_wrap", 3'd2, 4'd4,  4'd1,  4'd2,  16'h0000, 16'h0001, 16'hFFFF};
        vecs[2] = '{"xor_alias",3'd4, 4'd5,  4'd5,  4'd5,  16'h00F0, 16'h00F0, 16'h0000};
        vecs[3] = '{"zero",     3'd0, 4'd6,  4'd1,  4'd2,  16'h1234, 16'h5678, 16'h0000};
        vecs[4] = '{"pass_a",   3'd3, 4'd8,  4'd9,  4'd10, 16'hBEEF, 16'h0001, 16'hBEEF};
        vecs[5] = '{"or",       3'd5, 4'd11, 4'd12, 4'd13, 16'h0F0F, 16'h3030, 16'h3F3F};
        vecs[6] = '{"and",      3'd6, 4'd14, 4'd12, 4'd13, 16'hF0F0, 16'h3C3C, 16'h3030};
        vecs[7] = '{"inc_wrap", 3'd7, 4'd15, 4'd15, 4'd0,  16'hFFFF, 16'h0000, 16'h0000};
        vecs[8] = '{"add_ovf",  3'd1, 4'd2,  4'd1,  4'd2,  16'h8000, 16'h8000, 16'h0000};

        reset_n     = 1'b1;
        instr       = 16'h0;
        instr_valid = 1'b0;
        ext_we      = 1'b0;
        ext_addr    = 4'h0;
        ext_data    = 16'h0;
        dbg_addr    = 4'h0;
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        #1;
        check("rst.alu_sel", {29'h0, alu_sel}, 32'd0);
        check("rst.alu_a", {16'h0, alu_a}, 32'd0);
        check("rst.alu_b", {16'h0, alu_b}, 32'd0);
        check("rst.done", {31'h0, done}, 32'd0);
        check("rst.busy", {31'h0, busy}, 32'd0);
        check("rst.instr_ready", {31'h0, instr_ready}, 32'd1);
`ifdef ALU_SEQ_FLAGS_EN
        check("rst.zero_flag", {31'h0, zero_flag}, 32'd0);
        check("rst.neg_flag", {31'h0, neg_flag}, 32'd0);
`endif
        for (int a = 0; a < 16; a++) begin
            check_reg("rst.reg", 4'(a), 16'h0000);
        end

        // Idle with no valid: nothing moves.
        @(posedge clk);
        #1;
        check("idle.busy", {31'h0, busy}, 32'd0);

        for (int i = 0; i < 9; i++) begin
            ext_write(vecs[i].ra, vecs[i].av);
            ext_write(vecs[i].rb, vecs[i].bv);
            issue(vecs[i].nm, vecs[i].op, vecs[i].rd, vecs[i].ra, vecs[i].rb,
                  vecs[i].av, vecs[i].bv, vecs[i].exp);
        end

        // Chained wrap: r4 = 0 - 1, then r4 = r4 + 1 using its own old value.
        ext_write(4'd1, 16'h0000);
        ext_write(4'd2, 16'h0001);
        issue("chain_sub", 3'd2, 4'd4, 4'd1, 4'd2, 16'h0000, 16'h0001, 16'hFFFF);
        issue("chain_inc", 3'd7, 4'd4, 4'd4, 4'd0, 16'hFFFF, 16'h0000, 16'h0000);

        // ext_we beats a simultaneous instruction.
        instr       = {3'd1, 1'b0, 4'd10, 4'd1, 4'd2};
        instr_valid = 1'b1;
        ext_we      = 1'b1;
        ext_addr    = 4'd9;
        ext_data    = 16'h1111;
        #1;
        check("prio.instr_ready", {31'h0, instr_ready}, 32'd0);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        ext_we      = 1'b0;
        check("prio.busy", {31'h0, busy}, 32'd0);
        check_reg("prio.r9", 4'd9, 16'h1111);

        // ext_we held during READ and EXEC must be dropped.
        ext_write(4'd1, 16'h0002);
        ext_write(4'd2, 16'h0003);
        instr       = {3'd1, 1'b0, 4'd7, 4'd1, 4'd2};
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        ext_we      = 1'b1;
        ext_addr    = 4'd1;
        ext_data    = 16'hDEAD;
        @(posedge clk);
        #1;
        check("busywr.alu_a", {16'h0, alu_a}, 32'h0002);
        @(posedge clk);
        #1;
        ext_we = 1'b0;
        @(posedge clk);
        #1;
        check_reg("busywr.r1", 4'd1, 16'h0002);
        check_reg("busywr.r7", 4'd7, 16'h0005);

        // Reset while in EXEC: no done, no writeback, everything cleared.
        instr       = {3'd1, 1'b0, 4'd12, 4'd1, 4'd2};
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(posedge clk);
        #1;
        check("midrst.in_exec", {31'h0, busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("midrst.busy", {31'h0, busy}, 32'd0);
        check("midrst.done0", {31'h0, done}, 32'd0);
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            check("midrst.done", {31'h0, done}, 32'd0);
        end
        reset_n = 1'b1;
        #1;
        check("midrst.alu_a", {16'h0, alu_a}, 32'd0);
        check("midrst.instr_ready", {31'h0, instr_ready}, 32'd1);
        check_reg("midrst.r12", 4'd12, 16'h0000);
        check_reg("midrst.r1", 4'd1, 16'h0000);
        check_reg("midrst.r7", 4'd7, 16'h0000);
        repeat (2) begin
            @(posedge clk);
            #1;
            check("midrst.post_done", {31'h0, done}, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
